conv_tile_sched_2x2: RTL and testbench

Tile sequencer for the 3-channel 2x2 convolution core. On a start pulse it latches the filter set and image geometry, then fetches each 2-row x 5-column x 3-channel pixel window from the image buffer and presents it to the core. It waits out the core latency, captures the four 16-bit results and hands them downstream on a valid/ready port. The block sits between the SPI-loaded image buffer and the result FIFO.

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_win_buf.sv | 33 +++
 rtl/conv_tile_sched_2x2.sv | 167 ++++++++++++++++
 tb/tb_conv_tile_sched_2x2.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the 2x2 convolution tile sequencer.
package conv_pkg;
  localparam int K         = 2;
  localparam int C         = 3;
  localparam int WIN_COLS  = 5;
  localparam int WIN_SLOTS = K * WIN_COLS;
  localparam int BYTE_W    = 8;
  localparam int SLOT_W    = 4;
  localparam int PIX_W     = 24;
  localparam int IMAGE_W   = 240;
  localparam int FILTER_W  = 96;
  localparam int OUT_W     = 64;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_OUT, ST_FIN} state_t;
endpackage

// File: rtl/conv_win_buf.sv
// 10-slot pixel window; slots are stored pixel-major and presented channel-major.
module conv_win_buf
  import conv_pkg::*;
(
  input  logic               clk_spi,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [SLOT_W-1:0]  wr_slot,
  input  logic [PIX_W-1:0]   wr_data,
  output logic [IMAGE_W-1:0] image
);
  genvar gi, gc;
  generate
    for (gi = 0; gi < WIN_SLOTS; gi++) begin : g_slot
      logic [PIX_W-1:0] slot_q, slot_d;

      always_comb begin
        slot_d = slot_q;
        if (wr_en && wr_slot == SLOT_W'(gi)) slot_d = wr_data;
      end

      always_ff @(posedge clk_spi or posedge rst) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
      end

      // Channel ch of slot j lands in byte j of the ch-th 80-bit plane.
      for (gc = 0; gc < C; gc++) begin : g_ch
        assign image[WIN_SLOTS*BYTE_W*gc + BYTE_W*gi +: BYTE_W] = slot_q[BYTE_W*gc +: BYTE_W];
      end
    end
  endgenerate
endmodule

// File: rtl/conv_tile_sched_2x2.sv
// Tile sequencer: fetches 2x5x3 windows from the image buffer, waits out the
// core latency and hands each 64-bit result downstream on a valid/ready port.
module conv_tile_sched_2x2
  import conv_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DIM_W    = 8,
  parameter int CORE_LAT = 2
) (
  input  logic                clk_spi,
  input  logic                rst,
  input  logic                start,
  input  logic [DIM_W-1:0]    cfg_tiles_x,
  input  logic [DIM_W-1:0]    cfg_rows,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [FILTER_W-1:0] filter_in,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [PIX_W-1:0]    rd_data,
  output logic [IMAGE_W-1:0]  core_image,
  output logic [FILTER_W-1:0] core_filter,
  input  logic [OUT_W-1:0]    core_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic [DIM_W-1:0]    out_row,
  output logic [DIM_W-1:0]    out_tile,
  output logic                busy,
  output logic                done
);
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(WIN_SLOTS);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CORE_LAT);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIM_W-1:0]    tiles_x_q, tiles_x_d, rows_q, rows_d;
  logic [DIM_W-1:0]    row_q, row_d, tile_q, tile_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [FILTER_W-1:0] filter_q, filter_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;

  logic                empty_cfg, second_row, win_we;
  logic [SLOT_W-1:0]   win_slot;
  logic [ADDR_W-1:0]   img_w, pix_row, pix_col;

  assign empty_cfg  = (tiles_x_q == '0) || (rows_q == '0);
  assign second_row = cnt_q >= CNT_W'(WIN_COLS);
  assign img_w      = ADDR_W'({tiles_x_q, 2'b00}) + ADDR_W'(1);
  assign pix_row    = ADDR_W'(row_q) + ADDR_W'(second_row);
  assign pix_col    = ADDR_W'({tile_q, 2'b00})
                    + ADDR_W'(second_row ? cnt_q - CNT_W'(WIN_COLS) : cnt_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tiles_x_d  = tiles_x_q;
    rows_d     = rows_q;
    row_d      = row_q;
    tile_d     = tile_q;
    base_d     = base_q;
    filter_d   = filter_q;
    out_data_d = out_data_q;
    rd_en      = 1'b0;
    rd_addr    = '0;
    win_we     = 1'b0;
    win_slot   = SLOT_W'(cnt_q - CNT_W'(1));
    out_valid  = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tiles_x_d = cfg_tiles_x;
          rows_d    = cfg_rows;
          base_d    = cfg_base;
          filter_d  = filter_in;
          row_d     = '0;
          tile_d    = '0;
          cnt_d     = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Empty geometry is only known once latched, so it exits from here without reads.
        if (empty_cfg) begin
          state_d = ST_FIN;
        end else begin
          rd_en  = cnt_q < LOAD_LAST;
          win_we = cnt_q != '0;
          if (rd_en) rd_addr = base_q + pix_row * img_w + pix_col;
          if (cnt_q == LOAD_LAST) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          out_data_d = core_out;
          state_d    = ST_OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
          if (tile_q == tiles_x_q - DIM_W'(1)) begin
            tile_d = '0;
            row_d  = row_q + DIM_W'(1);
            if (row_q == rows_q - DIM_W'(1)) state_d = ST_FIN;
          end else begin
            tile_d = tile_q + DIM_W'(1);
          end
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_spi or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tiles_x_q  <= '0;
      rows_q     <= '0;
      row_q      <= '0;
      tile_q     <= '0;
      base_q     <= '0;
      filter_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tiles_x_q  <= tiles_x_d;
      rows_q     <= rows_d;
      row_q      <= row_d;
      tile_q     <= tile_d;
      base_q     <= base_d;
      filter_q   <= filter_d;
      out_data_q <= out_data_d;
    end
  end

  conv_win_buf u_win (
    .clk_spi (clk_spi),
    .rst     (rst),
    .wr_en   (win_we),
    .wr_slot (win_slot),
    .wr_data (rd_data),
    .image   (core_image)
  );

  assign core_filter = filter_q;
  assign out_data    = out_data_q;
  assign out_row     = row_q;
  assign out_tile    = tile_q;
  assign busy        = state_q != ST_IDLE;
endmodule

// File: tb/tb_conv_tile_sched_2x2.sv
// Bench for conv_tile_sched_2x2: buffer and two-stage core stubs, a cycle-level
// behavioural model with a per-cycle compare, and directed literal checks.
module tb_conv_tile_sched_2x2;
  import conv_pkg::*;
  localparam int ADDR_W = 12;
  localparam int DIM_W = 8;
  localparam int CORE_LAT = 2;
  localparam int NEVER = 32'h7fff_ffff;
  localparam logic [FILTER_W-1:0] F1 = 96'h0102030405060708090A0B0C;
  localparam logic [FILTER_W-1:0] F2 = 96'h111111111111111111111111;
  localparam logic [FILTER_W-1:0] F3 = 96'hA0B0C0D0E0F0010203040506;

  logic clk_spi = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [DIM_W-1:0] cfg_tiles_x = '0, cfg_rows = '0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [FILTER_W-1:0] filter_in = '0;
  logic rd_en, out_valid, busy, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0] rd_data = '0;
  logic [IMAGE_W-1:0] core_image;
  logic [FILTER_W-1:0] core_filter;
  logic [OUT_W-1:0] core_out = '0, core_s1 = '0, out_data;
  logic [DIM_W-1:0] out_row, out_tile;

  always #5 clk_spi = ~clk_spi;

  conv_tile_sched_2x2 #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CORE_LAT(CORE_LAT)) dut (
    .clk_spi(clk_spi), .rst(rst), .start(start), .cfg_tiles_x(cfg_tiles_x),
    .cfg_rows(cfg_rows), .cfg_base(cfg_base), .filter_in(filter_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .core_image(core_image),
    .core_filter(core_filter), .core_out(core_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_tile(out_tile), .busy(busy), .done(done));

  logic [PIX_W-1:0] mem [1<<ADDR_W];
  initial for (int a = 0; a < (1<<ADDR_W); a++) mem[a] = {3{a[7:0]}};

  function automatic logic [OUT_W-1:0] stub_core(input logic [IMAGE_W-1:0] img,
                                                 input logic [FILTER_W-1:0] f);
    logic [15:0] s [4];
    for (int l = 0; l < 4; l++) s[l] = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int j = 0; j < 10; j++) s[ch] = s[ch] + 16'(img[80*ch + 8*j +: 8]);
    for (int b = 0; b < 12; b++) s[3] = s[3] + 16'(f[8*b +: 8]);
    return {s[3], s[2], s[1], s[0]};
  endfunction

  always @(posedge clk_spi) begin
    if (rd_en) rd_data <= mem[rd_addr];
    core_s1  <= stub_core(core_image, core_filter);
    core_out <= core_s1;
  end

  // ---------------- model ----------------
  typedef struct { int row; int tile; } tile_t;
  tile_t m_q[$];
  bit m_job = 0;
  int m_start_cyc = 0, m_busy_end = 0, m_done_cyc = -1, m_load_cyc = -1, m_valid_cyc = -1;
  int m_base = 0, m_w = 0;
  logic [FILTER_W-1:0] m_filter = '0;
  int cyc = 0, n_checks = 0, n_fail = 0, k = 0;
  bit exp_busy, exp_rd, exp_valid;
  logic prev_rd_en = 0, prev_busy = 0, prev_valid = 0;
  int addr_log[$], tag_log[$], hs_log[$], load_log[$], done_log[$], valid_log[$];
  int start_log[$], busy_rise[$], busy_fall[$];
  logic [OUT_W-1:0] data_log[$];

  always @(posedge clk_spi) cyc <= cyc + 1;

  function automatic logic [ADDR_W-1:0] pix_addr(input int y, input int x);
    return ADDR_W'(m_base + y * m_w + x);
  endfunction

  function automatic logic [IMAGE_W-1:0] model_window(input int row, input int tile);
    logic [IMAGE_W-1:0] w;
    logic [PIX_W-1:0] p;
    w = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 5; c++) begin
        p = mem[pix_addr(row + r, tile*4 + c)];
        for (int ch = 0; ch < 3; ch++) w[80*ch + 8*(r*5 + c) +: 8] = p[8*ch +: 8];
      end
    return w;
  endfunction

  function automatic logic [OUT_W-1:0] model_result(input int row, input int tile);
    int s [4];
    logic [PIX_W-1:0] p;
    for (int l = 0; l < 4; l++) s[l] = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 5; c++) begin
        p = mem[pix_addr(row + r, tile*4 + c)];
        for (int ch = 0; ch < 3; ch++) s[ch] += int'(p[8*ch +: 8]);
      end
    for (int b = 0; b < 12; b++) s[3] += int'(m_filter[8*b +: 8]);
    return {16'(s[3]), 16'(s[2]), 16'(s[1]), 16'(s[0])};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  always @(negedge clk_spi) begin
    if (rst) begin
      check("rst_ctl", {rd_en, rd_addr, out_valid, out_row, out_tile, busy, done}, '0);
      check("rst_data", out_data, '0);
      check("rst_img", core_image, '0);
      check("rst_filt", core_filter, '0);
      m_q.delete();
      m_job = 0; m_done_cyc = -1; m_load_cyc = -1; m_valid_cyc = -1;
    end else begin
      exp_busy  = m_job && cyc > m_start_cyc && cyc < m_busy_end;
      exp_rd    = m_load_cyc >= 0 && cyc >= m_load_cyc && cyc <= m_load_cyc + 9;
      exp_valid = m_valid_cyc >= 0 && cyc >= m_valid_cyc;
      check("busy", busy, exp_busy);
      check("done", done, cyc == m_done_cyc);
      check("rd_en", rd_en, exp_rd);
      check("out_valid", out_valid, exp_valid);
      if (exp_rd) begin
        k = cyc - m_load_cyc;
        check("rd_addr", rd_addr, pix_addr(m_q[0].row + k/5, m_q[0].tile*4 + k%5));
      end
      if (exp_busy) check("core_filter", core_filter, m_filter);
      if (m_valid_cyc >= 0 && cyc == m_valid_cyc - 3)
        check("core_image", core_image, model_window(m_q[0].row, m_q[0].tile));
      if (exp_valid) begin
        check("out_data", out_data, model_result(m_q[0].row, m_q[0].tile));
        check("out_tag", {out_row, out_tile}, {8'(m_q[0].row), 8'(m_q[0].tile)});
      end
      if (rd_en) addr_log.push_back(int'(rd_addr));
      if (rd_en && !prev_rd_en) load_log.push_back(cyc);
      if (out_valid && !prev_valid) valid_log.push_back(cyc);
      if (done) done_log.push_back(cyc);
      if (busy && !prev_busy) busy_rise.push_back(cyc);
      if (!busy && prev_busy) busy_fall.push_back(cyc);
      if (out_valid && out_ready) begin
        hs_log.push_back(cyc);
        tag_log.push_back(int'({out_row, out_tile}));
        data_log.push_back(out_data);
      end
      if (exp_valid && out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_done_cyc = cyc + 1; m_busy_end = cyc + 2; m_load_cyc = -1; m_valid_cyc = -1;
        end else begin
          m_load_cyc = cyc + 1; m_valid_cyc = cyc + 15;
        end
      end
      if (start && !exp_busy) begin
        start_log.push_back(cyc);
        m_job = 1; m_start_cyc = cyc;
        m_base = int'(cfg_base); m_w = 4 * int'(cfg_tiles_x) + 1; m_filter = filter_in;
        m_q.delete();
        if (cfg_tiles_x == 0 || cfg_rows == 0) begin
          m_done_cyc = cyc + 2; m_busy_end = cyc + 3; m_load_cyc = -1; m_valid_cyc = -1;
        end else begin
          for (int r = 0; r < int'(cfg_rows); r++)
            for (int t = 0; t < int'(cfg_tiles_x); t++) m_q.push_back('{r, t});
          m_done_cyc = -1; m_busy_end = NEVER; m_load_cyc = cyc + 1; m_valid_cyc = cyc + 15;
        end
      end
    end
    prev_rd_en = rd_en; prev_busy = busy; prev_valid = out_valid;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_spi); #1;
  endtask

  task automatic do_start(input int tx, input int rows, input int base, input logic [FILTER_W-1:0] f);
    cfg_tiles_x = DIM_W'(tx); cfg_rows = DIM_W'(rows); cfg_base = ADDR_W'(base);
    filter_in = f; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    tick();
    while (busy && n < budget) begin tick(); n++; end
    check({name, "_timeout"}, busy, 1'b0);
    tick();
  endtask

  task automatic clear_logs();
    addr_log.delete(); tag_log.delete(); hs_log.delete(); load_log.delete();
    done_log.delete(); valid_log.delete(); start_log.delete();
    busy_rise.delete(); busy_fall.delete(); data_log.delete();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single tile, base 0
    clear_logs();
    do_start(1, 1, 0, F1);
    wait_idle("t1", 100);
    check("t1_naddr", addr_log.size(), 10);
    for (int i = 0; i < 10; i++) check("t1_addr", qat(addr_log, i), i);
    check("t1_valid_lat", qat(valid_log, 0) - qat(start_log, 0), 15);
    check("t1_done_lat", qat(done_log, 0) - qat(hs_log, 0), 1);
    check("t1_busy_fall", qat(busy_fall, 0) - qat(hs_log, 0), 2);
    check("t1_data", data_log.size() > 0 ? data_log[0] : '0, 64'h004E_002D_002D_002D);

    // 2x2 tiles at base 0x100
    clear_logs();
    do_start(2, 2, 'h100, F2);
    wait_idle("t2", 200);
    check("t2_addr0", qat(addr_log, 0), 'h100);
    check("t2_addr1", qat(addr_log, 10), 'h104);
    check("t2_addr2", qat(addr_log, 20), 'h109);
    check("t2_addr3", qat(addr_log, 30), 'h10D);
    check("t2_tag0", qat(tag_log, 0), 'h000);
    check("t2_tag1", qat(tag_log, 1), 'h001);
    check("t2_tag2", qat(tag_log, 2), 'h100);
    check("t2_tag3", qat(tag_log, 3), 'h101);
    check("t2_period", qat(hs_log, 1) - qat(hs_log, 0), 15);

    // backpressure: ready low for 20 cycles at first OUT
    clear_logs();
    out_ready = 1'b0;
    do_start(2, 1, 'h20, F3);
    n = 0;
    while (!out_valid && n < 30) begin tick(); n++; end
    check("t3_valid_timeout", out_valid, 1'b1);
    repeat (20) tick();
    out_ready = 1'b1;
    wait_idle("t3", 100);
    check("t3_stall", qat(hs_log, 0) - qat(valid_log, 0), 20);
    check("t3_reload", qat(load_log, 1) - qat(hs_log, 0), 1);

    // zero geometry
    clear_logs();
    do_start(3, 0, 'h10, F1);
    wait_idle("t4", 20);
    check("t4_done", qat(done_log, 0) - qat(start_log, 0), 2);
    check("t4_busy_rise", qat(busy_rise, 0) - qat(start_log, 0), 1);
    check("t4_busy_fall", qat(busy_fall, 0) - qat(start_log, 0), 3);
    check("t4_noreads", addr_log.size(), 0);

    // reset mid-LOAD at k=6, then a fresh wrapping job
    clear_logs();
    do_start(1, 1, 'h40, F1);
    repeat (6) tick();
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("t5_reads_before_rst", addr_log.size(), 6);
    check("t5_no_done", done_log.size(), 0);
    clear_logs();
    do_start(1, 1, 'hFFE, F2);
    wait_idle("t5", 100);
    check("t5_addr0", qat(addr_log, 0), 'hFFE);
    check("t5_wrap", qat(addr_log, 2), 'h000);
    check("t5_wrap_row1", qat(addr_log, 5), 'h003);

    // start during WAIT is ignored
    clear_logs();
    do_start(1, 1, 'h200, F1);
    repeat (12) tick();
    do_start(4, 3, 'h300, F2);
    wait_idle("t6", 100);
    check("t6_accepted", start_log.size(), 1);
    check("t6_results", hs_log.size(), 1);
    check("t6_addr0", qat(addr_log, 0), 'h200);
    check("t6_data", data_log.size() > 0 ? data_log[0] : '0, 64'h004E_002D_002D_002D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
